bus_mem_port: RTL and testbench

BUS_MEM_PORT -- requirements
Module: bus_mem_port

---
 rtl/bus_mem_port_pkg.sv | 43 ++++
 rtl/bus_mem_port_tx_fifo.sv | 62 ++++++
 rtl/bus_mem_port.sv | 147 ++++++++++++++
 tb/tb_bus_mem_port.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_mem_port_pkg.sv
// Shared definitions for bus_mem_port: default addresses, access size codes,
// the bus FSM state type and lane helpers.
package bus_mem_port_pkg;

   localparam logic [31:0] TX_ADDR_DEF   = 32'h1000_0000;
   localparam logic [31:0] STAT_ADDR_DEF = 32'h1000_0004;

   localparam logic [2:0] SZ_B = 3'd0;
   localparam logic [2:0] SZ_H = 3'd1;
   localparam logic [2:0] SZ_W = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACK   = 2'd1,
      ST_STALL = 2'd2
   } state_t;

   // Byte lanes touched by an access of the given size at the given low address bits.
   function automatic logic [3:0] lane_enables(input logic [2:0] size, input logic [1:0] lane);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         SZ_B:    be = 4'b0001 << lane;
         SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
         SZ_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lane);
      logic bad;
      bad = 1'b1;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = lane[0];
         SZ_W:    bad = (lane != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/bus_mem_port_tx_fifo.sv
// tx_fifo: byte FIFO with an occupancy count; the head byte is visible
// combinationally so the consumer sees it in the same cycle as tx_valid.
module tx_fifo
   import bus_mem_port_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic [7:0]                    din,
   output logic [7:0]                    dout,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic [AW:0]   count_next;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_reg == (AW+1)'(FIFO_DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign dout    = mem[rd_ptr_reg];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      count_next = count_reg;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + (AW+1)'(1);
         2'b01:   count_next = count_reg - (AW+1)'(1);
         default: count_next = count_reg;
      endcase
   end

   // Pointers are AW bits wide so they wrap modulo the power-of-two depth for free.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !rst) mem[wr_ptr_reg] <= din;
   end

endmodule

// File: rtl/bus_mem_port.sv
// bus_mem_port: one-cycle-latency bus slave exposing a byte-enabled data RAM,
// a TX byte FIFO and a status register, with a sticky access-error flag.
module bus_mem_port
   import bus_mem_port_pkg::*;
#(
   parameter int          RAM_WORDS  = 256,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] TX_ADDR    = TX_ADDR_DEF,
   parameter logic [31:0] STAT_ADDR  = STAT_ADDR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [2:0]  size,
   input  logic        valid,
   input  logic        write,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        err
);

   localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int CW     = $clog2(FIFO_DEPTH) + 1;

   state_t            state_reg;
   state_t            state_next;
   logic              hit_ram;
   logic              hit_tx;
   logic              hit_stat;
   logic              bad;
   logic [3:0]        be;
   logic [RAM_AW-1:0] ram_idx;
   logic              ack;
   logic              tx_store;
   logic              ram_we;
   logic              push;
   logic              pop;
   logic [7:0]        tx_byte;
   logic [7:0]        fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [31:0]       ram_q;
   logic [31:0]       stat_word;
   logic              err_reg;

   // Address decode; the master holds addr/size/write stable until ready.
   assign hit_ram  = (addr[31:2] < 30'(RAM_WORDS));
   assign hit_tx   = (addr == TX_ADDR);
   assign hit_stat = (addr == STAT_ADDR);
   assign bad      = misaligned(size, addr[1:0]) || !(hit_ram || hit_tx || hit_stat);
   assign be       = lane_enables(size, addr[1:0]);
   assign ram_idx  = addr[RAM_AW+1:2];

   assign ack      = (state_reg == ST_ACK);
   assign tx_store = valid && write && hit_tx && !bad;
   assign ram_we   = ack && valid && write && hit_ram && !bad && !rst;
   assign push     = ack && tx_store && !rst;

   always_comb begin
      tx_byte = wdata[7:0];
      case (addr[1:0])
         2'd0:    tx_byte = wdata[7:0];
         2'd1:    tx_byte = wdata[15:8];
         2'd2:    tx_byte = wdata[23:16];
         default: tx_byte = wdata[31:24];
      endcase
   end

   // A full FIFO seen in IDLE parks the store in STALL; a pop in that same
   // cycle only frees the slot for the following cycle.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (valid) state_next = (tx_store && fifo_full) ? ST_STALL : ST_ACK;
         end
         ST_ACK: begin
            state_next = ST_IDLE;
         end
         ST_STALL: begin
            if (!fifo_full) state_next = ST_ACK;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (ack && valid && bad) err_reg <= 1'b1;
      end
   end

   // One byte-wide array per lane gives byte-enabled writes with a registered read.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [RAM_WORDS];
         logic [7:0] lane_q_reg;
         always_ff @(posedge clk) begin
            lane_q_reg <= lane_mem[ram_idx];
            if (ram_we && be[gi]) lane_mem[ram_idx] <= wdata[gi*8 +: 8];
         end
         assign ram_q[gi*8 +: 8] = lane_q_reg;
      end
   endgenerate

   tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (tx_byte),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign stat_word = {24'b0, 4'(fifo_count), 2'b00, fifo_full, fifo_empty};

   always_comb begin
      rdata = '0;
      if (ready && valid && !write && !bad) begin
         if (hit_ram)       rdata = ram_q;
         else if (hit_stat) rdata = stat_word;
      end
   end

   assign ready    = ack && !rst;
   assign tx_valid = !fifo_empty && !rst;
   assign tx_data  = tx_valid ? fifo_dout : 8'h00;
   assign pop      = tx_valid && tx_ready;
   assign err      = err_reg && !rst;

endmodule

// File: tb/tb_bus_mem_port.sv
// tb_bus_mem_port: scoreboard bench for bus_mem_port; a byte-level memory and a
// byte queue model the expected loads, TX bytes and error flag.
module tb_bus_mem_port;
   import bus_mem_port_pkg::*;

   localparam logic [31:0] TXA = 32'h1000_0000;
   localparam logic [31:0] STA = 32'h1000_0004;

   typedef struct {
      bit          chk;
      logic [31:0] val;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = '0;
   logic [2:0]  size = '0;
   logic        valid = 1'b0;
   logic        write = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        err;

   int   checks = 0;
   int   passes = 0;
   bit   rnd_mode = 1'b0;
   logic err_m = 1'b0;
   logic [7:0] ram_m [0:1023];
   logic [7:0] txq [$];
   exp_t       expq [$];

   bus_mem_port dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .size     (size),
      .valid    (valid),
      .write    (write),
      .wdata    (wdata),
      .rdata    (rdata),
      .ready    (ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, got, want);
   endtask

   function automatic bit is_bad(input logic [31:0] a, input logic [2:0] sz);
      if (sz > 3'd2) return 1'b1;
      if ((a % (32'd1 << sz)) != 0) return 1'b1;
      return !(a < 32'd1024 || a == TXA || a == STA);
   endfunction

   function automatic logic [31:0] stat_model();
      int   n;
      logic f;
      logic e;
      n = txq.size();
      f = (n == 8);
      e = (n == 0);
      return {24'b0, 4'(n), 2'b00, f, e};
   endfunction

   // Applies one access to the model; returns 1 when the store cannot stall.
   function automatic bit prepare(input logic [31:0] a, input logic [2:0] sz, input bit wr,
                                  input logic [31:0] wd);
      exp_t        e;
      bit          may_stall;
      logic [31:0] base;
      base      = a & ~32'h3;
      e.chk     = !wr;
      e.val     = '0;
      may_stall = 1'b0;
      if (is_bad(a, sz)) begin
         err_m = 1'b1;
      end else if (wr) begin
         if (a < 32'd1024) begin
            for (int k = 0; k < (1 << sz); k++) ram_m[a + k] = wd[8 * ((a + k) % 4) +: 8];
         end else if (a == TXA) begin
            may_stall = (txq.size() >= 8);
            txq.push_back(wd[8 * (a % 4) +: 8]);
         end
      end else begin
         if (a < 32'd1024) e.val = {ram_m[base + 3], ram_m[base + 2], ram_m[base + 1], ram_m[base]};
         else if (a == STA) e.val = stat_model();
      end
      expq.push_back(e);
      return !may_stall;
   endfunction

   task automatic access(input logic [31:0] a, input logic [2:0] sz, input bit wr, input logic [31:0] wd);
      bit lat_known;
      int cyc;
      @(posedge clk); #1;
      if (rnd_mode) tx_ready = 1'($urandom_range(0, 1));
      lat_known = prepare(a, sz, wr, wd);
      addr = a; size = sz; write = wr; wdata = wd; valid = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         if (rnd_mode) tx_ready = 1'($urandom_range(0, 1));
         cyc++;
         @(negedge clk);
      end while (!ready && cyc < 64);
      check("ready_seen", 32'(ready), 32'd1);
      if (lat_known) check("latency", cyc, 1);
      @(posedge clk); #1;
      valid = 1'b0;
      if (rnd_mode) tx_ready = 1'($urandom_range(0, 1));
      check("err", 32'(err), 32'(err_m));
   endtask

   // Issues a TX store expected to stall on a full FIFO; leaves valid high.
   task automatic stall_start(input logic [7:0] b);
      @(posedge clk); #1;
      void'(prepare(TXA, SZ_B, 1'b1, {24'b0, b}));
      addr = TXA; size = SZ_B; write = 1'b1; wdata = {24'b0, b}; valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("stall_hold", 32'(ready), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   task automatic reset_checks();
      @(negedge clk);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_err", 32'(err), 32'd0);
   endtask

   task automatic drain();
      @(posedge clk); #1;
      tx_ready = 1'b1;
      for (int i = 0; i < 40 && tx_valid; i++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("drained_tx_valid", 32'(tx_valid), 32'd0);
      check("drained_model", txq.size(), 0);
   endtask

   // Response monitor: each ready pulse consumes the oldest expected response.
   initial begin
      bit   prev_ready;
      exp_t e;
      prev_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (ready) begin
            check("ready_single", 32'(prev_ready), 32'd0);
            if (expq.size() == 0) begin
               checks++;
               $display("FAIL ready_unexpected: got ready=1 with nothing outstanding, want ready=0");
            end else begin
               e = expq.pop_front();
               if (e.chk) check("rdata", rdata, e.val);
            end
         end else begin
            check("rdata_idle", rdata, 32'd0);
         end
         prev_ready = ready;
      end
   end

   // TX monitor: every accepted byte must match the model queue head.
   initial begin
      forever begin
         @(negedge clk);
         if (tx_valid && tx_ready) begin
            if (txq.size() == 0) begin
               checks++;
               $display("FAIL tx_unexpected: got byte 0x%02h, want no byte", tx_data);
            end else begin
               check("tx_data", 32'(tx_data), 32'(txq.pop_front()));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish by time limit, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          r;
      logic [31:0] a;
      logic [2:0]  sz;
      bit          wr;

      reset_checks();
      reset_checks();
      @(posedge clk); #1;
      rst = 1'b0;

      for (int w = 0; w < 16; w++) access(w * 4, SZ_W, 1'b1, $urandom);
      access(32'h3FC, SZ_W, 1'b1, 32'hCAFE_F00D);

      access(32'h10, SZ_W, 1'b1, 32'hDEAD_BEEF);
      access(32'h10, SZ_W, 1'b0, 32'h0);
      access(32'h11, SZ_B, 1'b1, 32'h0000_AB00);
      access(32'h10, SZ_W, 1'b0, 32'h0);
      access(32'h22, SZ_H, 1'b1, 32'h1234_0000);
      access(32'h20, SZ_H, 1'b0, 32'h0);
      access(32'h3FC, SZ_B, 1'b0, 32'h0);
      access(TXA, SZ_W, 1'b0, 32'h0);
      access(STA, SZ_W, 1'b1, 32'hFFFF_FFFF);
      access(STA, SZ_W, 1'b0, 32'h0);

      tx_ready = 1'b0;
      access(TXA, SZ_B, 1'b1, 32'h0000_0048);
      access(TXA, SZ_B, 1'b1, 32'h0000_0069);
      access(STA, SZ_W, 1'b0, 32'h0);
      drain();

      @(posedge clk); #1;
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) access(TXA, SZ_B, 1'b1, 32'h30 + i);
      stall_start(8'h5A);
      tx_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      tx_ready = 1'b0;
      @(negedge clk);
      check("stall_pop_plus1", 32'(ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_pop_plus2", 32'(ready), 32'd1);
      @(posedge clk); #1;
      valid = 1'b0;
      access(STA, SZ_W, 1'b0, 32'h0);
      drain();

      access(32'h2000_0000, SZ_W, 1'b0, 32'h0);
      access(32'h2, SZ_W, 1'b1, 32'h1111_1111);
      access(32'h1, SZ_H, 1'b1, 32'h2222_2222);
      access(32'h4, 3'd3, 1'b1, 32'h3333_3333);
      access(32'h400, SZ_W, 1'b1, 32'h4444_4444);
      access(32'h0, SZ_W, 1'b0, 32'h0);
      access(32'h4, SZ_W, 1'b0, 32'h0);

      @(posedge clk); #1;
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) access(TXA, SZ_B, 1'b1, 32'h60 + i);
      stall_start(8'hEE);
      rst = 1'b1;
      valid = 1'b0;
      reset_checks();
      reset_checks();
      @(posedge clk); #1;
      rst = 1'b0;
      txq.delete();
      expq.delete();
      err_m = 1'b0;
      @(negedge clk);
      check("post_rst_tx_valid", 32'(tx_valid), 32'd0);
      access(STA, SZ_W, 1'b0, 32'h0);
      access(32'h10, SZ_W, 1'b0, 32'h0);

      rnd_mode = 1'b1;
      for (int n = 0; n < 300; n++) begin
         r  = $urandom_range(0, 99);
         wr = 1'($urandom_range(0, 1));
         if (r < 50) begin
            sz = 3'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 15)) * 4;
            if (sz == SZ_B) a = a + 32'($urandom_range(0, 3));
            else if (sz == SZ_H) a = a + 32'($urandom_range(0, 1)) * 2;
         end else if (r < 75) begin
            sz = SZ_B; a = TXA; wr = 1'b1;
         end else if (r < 82) begin
            sz = SZ_W; a = TXA; wr = 1'b0;
         end else if (r < 88) begin
            sz = SZ_W; a = STA; wr = 1'b1;
         end else if (r < 94) begin
            sz = 3'($urandom_range(1, 3));
            a  = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
         end else begin
            sz = SZ_W;
            a  = 32'h2000_0000 + 32'($urandom_range(0, 255)) * 4;
         end
         access(a, sz, wr, $urandom);
      end
      rnd_mode = 1'b0;
      drain();
      check("responses_consumed", expq.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
